eve_parent_streamer: RTL and testbench
======================================

Name: eve_parent_streamer

Overview:
- Transmit side of the PE parent-gene interface. Fetches two parent genomes from a shared single-port gene memory and pushes them pairwise into the PE's parent FIFOs.
- Outputs drive parent1/parent2/wr_en/genomeID of the PE.
- Credit-based flow control prevents FIFO overflow.
- Sits between the population memory controller and one PE.

Parameters:
GENE_W, 64, gene width (one word per gene)
ADDR_W, 10, gene memory address width
LEN_W, 8, genome length field width (genes per genome)
CREDITS, 8, PE parent-FIFO depth; initial and maximum credit count

Ports:
input_clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request; accepted only in IDLE
base_a  in  ADDR_W  parent A start address
base_b  in  ADDR_W  parent B start address
len_a  in  LEN_W  parent A gene count
len_b  in  LEN_W  parent B gene count
genome_id_in  in  8  child genome ID for this job
busy  out  1  high from the cycle after start is accepted until DONE exits
done  out  1  one-cycle pulse, job complete
mem_rd_en  out  1  memory read strobe; rdata valid next cycle
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  GENE_W  memory read data, 1-cycle latency
parent1  out  GENE_W  gene pushed to parent A FIFO
parent2  out  GENE_W  gene pushed to parent B FIFO
wr_en  out  1  push strobe to both parent FIFOs
genomeID  out  8  latched genome_id_in, held stable for the job
credit_ret  in  1  one-cycle pulse per pair popped by the PE
checksum  out  GENE_W  see Optional Feature

Behaviour:
- Reset (reset==0 at clock edge), including mid-job:
  - state=IDLE; credits=CREDITS; index=0.
  - All outputs 0.
  - Any in-flight read is discarded.
- start in IDLE latches base_a, base_b, len_a, len_b and genome_id_in (genomeID updates next cycle).
- pair_cnt = max(len_a, len_b). start outside IDLE is ignored.
- If pair_cnt==0: go to DONE directly. No reads, no wr_en.
- States:
  - IDLE -> RD_A on accepted start with pair_cnt>0.
  - RD_A:
    - If credits==0, stall here; mem_rd_en=0.
    - Otherwise decrement credits.
    - If index<len_a: mem_rd_en=1, mem_addr=base_a+index. Else no read and A is the pad gene (all zeros).
    - -> RD_B.
  - RD_B:
    - Capture A data from mem_rdata (or pad).
    - If index<len_b: mem_rd_en=1, mem_addr=base_b+index. Else pad.
    - -> PUSH.
  - PUSH:
    - Register parent1=A, parent2=B data (or pad).
    - wr_en=1 in the following cycle for exactly one cycle.
    - index++.
    - -> RD_A if index<pair_cnt, else DONE.
  - DONE: done=1 for one cycle -> IDLE. busy=0 the same cycle DONE exits.
- Timing:
  - First wr_en occurs 3 cycles after the RD_A entry that is not stalled.
  - Peak throughput is 1 pair per 3 cycles.
- parent1/parent2 hold their last value when wr_en=0.
- Address arithmetic is modulo 2^ADDR_W (wraps, no error).
- Credits:
  - credit_ret alone increments; an RD_A issue alone decrements; both in the same cycle leave credits unchanged.
  - credit_ret at credits==CREDITS is ignored (saturate).
  - Credits persist across jobs; only reset restores them.
- mem_rd_en is never asserted outside RD_A/RD_B.

Optional Feature:
- Macro: EVE_STREAM_CHECKSUM_EN.
- Defined:
  - checksum clears on accepted start.
  - Every push XORs parent1^parent2 into checksum.
  - Final value is valid when done=1 and is held until the next start or reset.
- Undefined: checksum is tied to 0 and no checksum register is built.

Test Plan:
- len_a=len_b=2, mem[base_a..]=0x11,0x22, mem[base_b..]=0x33,0x44 -> two wr_en pulses with pairs (0x11,0x33) then (0x22,0x44), then done; with the macro, checksum=0x11^0x33^0x22^0x44=0x44.
- len_a=3, len_b=1 -> 3 pushes; parent2 = mem[base_b], 0, 0; no reads beyond base_b+0; done after the third push.
- CREDITS=2, len=4, no credit_ret -> exactly 2 wr_en, then the FSM stalls in RD_A with mem_rd_en=0; one credit_ret -> third push; another credit_ret -> fourth push and done.
- len_a=len_b=0, start -> done pulse, zero wr_en, zero mem_rd_en.
- reset=0 asserted in RD_B mid-job -> next cycle all outputs 0 and state IDLE; credits=CREDITS; a new start runs normally from index 0.
- base_a=2^ADDR_W-1, len_a=2 -> mem_addr sequence 1023 then 0.

Source files
------------

// File: rtl/eve_parent_streamer.sv
// eve_parent_streamer: transmit side of the PE parent-gene interface.
// Fetches parent A and parent B genes from a single-port gene memory (one
// read per state, 1-cycle read latency) and pushes them pairwise into the
// PE parent FIFOs, gated by a credit counter that mirrors FIFO free space.
// Optional feature macro: EVE_STREAM_CHECKSUM_EN (running XOR of pushes).
// All outputs are registered; read strobes are computed one cycle ahead
// from the next-state values so they line up with the RD_A/RD_B states.
module eve_parent_streamer #(
   parameter int GENE_W  = 64,
   parameter int ADDR_W  = 10,
   parameter int LEN_W   = 8,
   parameter int CREDITS = 8
) (
   input  logic              input_clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [LEN_W-1:0]  len_a,
   input  logic [LEN_W-1:0]  len_b,
   input  logic [7:0]        genome_id_in,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [GENE_W-1:0] mem_rdata,
   output logic [GENE_W-1:0] parent1,
   output logic [GENE_W-1:0] parent2,
   output logic              wr_en,
   output logic [7:0]        genomeID,
   input  logic              credit_ret,
   output logic [GENE_W-1:0] checksum
);

   localparam int                CRED_W   = $clog2(CREDITS + 1);
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD_A = 3'd1,
      S_RD_B = 3'd2,
      S_PUSH = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_r, state_nxt_s;
   logic [CRED_W-1:0]   credits_r, credits_nxt_s;
   logic [LEN_W-1:0]    index_r, index_nxt_s;
   logic [LEN_W:0]      index_inc_s;
   logic [ADDR_W-1:0]   base_a_r, base_b_r;
   logic [LEN_W-1:0]    len_a_r, len_b_r, pair_cnt_r;
   logic [ADDR_W-1:0]   base_a_nxt_s, base_b_nxt_s;
   logic [LEN_W-1:0]    len_a_nxt_s, len_b_nxt_s, pair_cnt_in_s;
   logic                accept_s;
   logic                rd_issue_s;
   logic                rvalid_r;
   logic [GENE_W-1:0]   a_data_r;
   logic [GENE_W-1:0]   rd_gene_s;
   logic                rd_en_nxt_s;
   logic [ADDR_W-1:0]   addr_nxt_s;
   logic                busy_r, done_r, mem_rd_en_r, wr_en_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [GENE_W-1:0]   parent1_r, parent2_r;
   logic [7:0]          genome_id_r;

   // Job acceptance, job-parameter lookahead and returned read data selection
   always_comb begin
      accept_s      = (state_r == S_IDLE) && start;
      pair_cnt_in_s = (len_a > len_b) ? len_a : len_b;
      if (accept_s) begin
         base_a_nxt_s = base_a;
         base_b_nxt_s = base_b;
         len_a_nxt_s  = len_a;
         len_b_nxt_s  = len_b;
      end else begin
         base_a_nxt_s = base_a_r;
         base_b_nxt_s = base_b_r;
         len_a_nxt_s  = len_a_r;
         len_b_nxt_s  = len_b_r;
      end
      // A gene beyond the genome length was never read: it is the zero pad
      if (rvalid_r) begin
         rd_gene_s = mem_rdata;
      end else begin
         rd_gene_s = {GENE_W{1'b0}};
      end
   end

   // Next-state, index and credit computation
   always_comb begin
      state_nxt_s = state_r;
      index_nxt_s = index_r;
      index_inc_s = {1'b0, index_r} + {{LEN_W{1'b0}}, 1'b1};
      rd_issue_s  = (state_r == S_RD_A) && (credits_r != {CRED_W{1'b0}});
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               index_nxt_s = {LEN_W{1'b0}};
               if (pair_cnt_in_s == {LEN_W{1'b0}}) begin
                  state_nxt_s = S_DONE;
               end else begin
                  state_nxt_s = S_RD_A;
               end
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RD_A: begin
            if (rd_issue_s) begin
               state_nxt_s = S_RD_B;
            end else begin
               state_nxt_s = S_RD_A;
            end
         end
         S_RD_B: state_nxt_s = S_PUSH;
         S_PUSH: begin
            index_nxt_s = index_inc_s[LEN_W-1:0];
            if (index_inc_s < {1'b0, pair_cnt_r}) begin
               state_nxt_s = S_RD_A;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         S_DONE: begin
            index_nxt_s = {LEN_W{1'b0}};
            state_nxt_s = S_IDLE;
         end
         default: begin
            index_nxt_s = {LEN_W{1'b0}};
            state_nxt_s = S_IDLE;
         end
      endcase

      // Simultaneous return and issue cancel; a return at full credit is dropped
      case ({credit_ret, rd_issue_s})
         2'b10: begin
            if (credits_r != CRED_MAX) begin
               credits_nxt_s = credits_r + {{(CRED_W-1){1'b0}}, 1'b1};
            end else begin
               credits_nxt_s = credits_r;
            end
         end
         2'b01:   credits_nxt_s = credits_r - {{(CRED_W-1){1'b0}}, 1'b1};
         default: credits_nxt_s = credits_r;
      endcase
   end

   // Read strobe/address for the coming cycle, so the registered outputs are
   // active exactly while the FSM sits in a non-stalled RD_A or in RD_B
   always_comb begin
      rd_en_nxt_s = 1'b0;
      addr_nxt_s  = {ADDR_W{1'b0}};
      if ((state_nxt_s == S_RD_A) && (credits_nxt_s != {CRED_W{1'b0}}) &&
          (index_nxt_s < len_a_nxt_s)) begin
         rd_en_nxt_s = 1'b1;
         addr_nxt_s  = base_a_nxt_s + ADDR_W'(index_nxt_s);
      end else if ((state_nxt_s == S_RD_B) && (index_nxt_s < len_b_nxt_s)) begin
         rd_en_nxt_s = 1'b1;
         addr_nxt_s  = base_b_nxt_s + ADDR_W'(index_nxt_s);
      end else begin
         rd_en_nxt_s = 1'b0;
         addr_nxt_s  = {ADDR_W{1'b0}};
      end
   end

   // Control state, credit counter and registered control outputs
   always_ff @(posedge input_clk) begin
      if (!reset) begin
         state_r     <= S_IDLE;
         credits_r   <= CRED_MAX;
         index_r     <= {LEN_W{1'b0}};
         rvalid_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         mem_rd_en_r <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         wr_en_r     <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         credits_r   <= credits_nxt_s;
         index_r     <= index_nxt_s;
         rvalid_r    <= mem_rd_en_r;
         busy_r      <= (state_nxt_s != S_IDLE);
         done_r      <= (state_nxt_s == S_DONE);
         mem_rd_en_r <= rd_en_nxt_s;
         mem_addr_r  <= addr_nxt_s;
         wr_en_r     <= (state_r == S_PUSH);
      end
   end

   // Job parameters, gene capture and parent output registers
   always_ff @(posedge input_clk) begin
      if (!reset) begin
         base_a_r    <= {ADDR_W{1'b0}};
         base_b_r    <= {ADDR_W{1'b0}};
         len_a_r     <= {LEN_W{1'b0}};
         len_b_r     <= {LEN_W{1'b0}};
         pair_cnt_r  <= {LEN_W{1'b0}};
         genome_id_r <= 8'd0;
         a_data_r    <= {GENE_W{1'b0}};
         parent1_r   <= {GENE_W{1'b0}};
         parent2_r   <= {GENE_W{1'b0}};
      end else begin
         if (accept_s) begin
            base_a_r    <= base_a;
            base_b_r    <= base_b;
            len_a_r     <= len_a;
            len_b_r     <= len_b;
            pair_cnt_r  <= pair_cnt_in_s;
            genome_id_r <= genome_id_in;
         end
         if (state_r == S_RD_B) begin
            a_data_r <= rd_gene_s;
         end
         if (state_r == S_PUSH) begin
            parent1_r <= a_data_r;
            parent2_r <= rd_gene_s;
         end
      end
   end

`ifdef EVE_STREAM_CHECKSUM_EN
   logic [GENE_W-1:0] checksum_r;

   // Running XOR of every pushed pair, cleared when a job is accepted
   always_ff @(posedge input_clk) begin
      if (!reset) begin
         checksum_r <= {GENE_W{1'b0}};
      end else if (accept_s) begin
         checksum_r <= {GENE_W{1'b0}};
      end else if (state_r == S_PUSH) begin
         checksum_r <= checksum_r ^ a_data_r ^ rd_gene_s;
      end else begin
         checksum_r <= checksum_r;
      end
   end

   assign checksum = checksum_r;
`else
   assign checksum = {GENE_W{1'b0}};
`endif

   assign busy      = busy_r;
   assign done      = done_r;
   assign mem_rd_en = mem_rd_en_r;
   assign mem_addr  = mem_addr_r;
   assign wr_en     = wr_en_r;
   assign parent1   = parent1_r;
   assign parent2   = parent2_r;
   assign genomeID  = genome_id_r;

endmodule

// File: tb/tb_eve_parent_streamer.sv
// Directed bench for eve_parent_streamer (CREDITS=2 so credit stalls are
// easy to reach). A behavioural memory with 1-cycle latency feeds the DUT;
// a monitor records pushed pairs and read addresses at the falling edge.
module tb_eve_parent_streamer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  base_a = 10'd0, base_b = 10'd0;
   logic [7:0]  len_a = 8'd0, len_b = 8'd0, genome_id_in = 8'd0;
   logic        busy, done, mem_rd_en, wr_en;
   logic [9:0]  mem_addr;
   logic [63:0] mem_rdata = 64'd0;
   logic [63:0] parent1, parent2, checksum;
   logic [7:0]  genomeID;
   logic        credit_ret;
   logic        auto_en = 1'b1, auto_pulse = 1'b0, man_pulse = 1'b0;

   logic [63:0] mem [0:1023];
   logic [63:0] p1_q[$], p2_q[$], addr_q[$];
   int          cyc = 0, first_wr = -1, start_cyc = 0;
   int          n_checks = 0, n_errors = 0;

`ifdef EVE_STREAM_CHECKSUM_EN
   localparam bit CK_ON = 1'b1;
`else
   localparam bit CK_ON = 1'b0;
`endif

   assign credit_ret = auto_pulse | man_pulse;

   eve_parent_streamer #(.GENE_W(64), .ADDR_W(10), .LEN_W(8), .CREDITS(2)) dut (
      .input_clk(clk), .reset(reset), .start(start),
      .base_a(base_a), .base_b(base_b), .len_a(len_a), .len_b(len_b),
      .genome_id_in(genome_id_in), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .parent1(parent1), .parent2(parent2), .wr_en(wr_en),
      .genomeID(genomeID), .credit_ret(credit_ret), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
      auto_pulse <= auto_en && wr_en;
   end

   always @(negedge clk) begin
      if (wr_en) begin
         p1_q.push_back(parent1);
         p2_q.push_back(parent2);
         if (first_wr < 0) first_wr = cyc;
      end
      if (mem_rd_en) addr_q.push_back({54'd0, mem_addr});
   end

   function automatic logic [63:0] ck(input logic [63:0] v);
      return CK_ON ? v : 64'd0;
   endfunction

   function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 64'hDEAD_DEAD_DEAD_DEAD;
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic job(input logic [9:0] ba, input logic [9:0] bb,
                      input logic [7:0] la, input logic [7:0] lb, input logic [7:0] gid);
      p1_q.delete(); p2_q.delete(); addr_q.delete(); first_wr = -1;
      @(posedge clk); #1;
      base_a = ba; base_b = bb; len_a = la; len_b = lb; genome_id_in = gid;
      start = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(negedge clk); n++;
      end
      check_eq(tag, {63'd0, done}, 64'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse_credit();
      @(posedge clk); #1 man_pulse = 1'b1;
      @(posedge clk); #1 man_pulse = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
      mem[100] = 64'h11; mem[101] = 64'h22; mem[200] = 64'h33; mem[201] = 64'h44;
      mem[300] = 64'hA1; mem[301] = 64'hA2; mem[302] = 64'hA3; mem[400] = 64'hB1;
      for (int i = 0; i < 4; i++) begin
         mem[500 + i] = 64'(i + 1);
         mem[600 + i] = 64'(i + 5);
      end
      mem[1023] = 64'hC1; mem[0] = 64'hC2;

      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_eq("rst_busy", {63'd0, busy}, 64'd0);
      check_eq("rst_done", {63'd0, done}, 64'd0);
      check_eq("rst_wr_en", {63'd0, wr_en}, 64'd0);
      check_eq("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
      check_eq("rst_gid", {56'd0, genomeID}, 64'd0);
      check_eq("rst_cksum", checksum, 64'd0);

      // basic 2-pair job
      job(10'd100, 10'd200, 8'd2, 8'd2, 8'h5A);
      check_eq("t1_busy", {63'd0, busy}, 64'd1);
      check_eq("t1_gid", {56'd0, genomeID}, 64'h5A);
      wait_done("t1_done");
      check_eq("t1_nwr", 64'(p1_q.size()), 64'd2);
      check_eq("t1_p1_0", qat(p1_q, 0), 64'h11);
      check_eq("t1_p2_0", qat(p2_q, 0), 64'h33);
      check_eq("t1_p1_1", qat(p1_q, 1), 64'h22);
      check_eq("t1_p2_1", qat(p2_q, 1), 64'h44);
      check_eq("t1_latency", 64'(first_wr - start_cyc), 64'd4);
      check_eq("t1_nrd", 64'(addr_q.size()), 64'd4);
      check_eq("t1_cksum", checksum, ck(64'h44));
      check_eq("t1_busy_end", {63'd0, busy}, 64'd0);

      // unequal lengths: B padded with zeros, no reads past base_b+0
      job(10'd300, 10'd400, 8'd3, 8'd1, 8'h01);
      wait_done("t2_done");
      check_eq("t2_nwr", 64'(p1_q.size()), 64'd3);
      check_eq("t2_p1_2", qat(p1_q, 2), 64'hA3);
      check_eq("t2_p2_0", qat(p2_q, 0), 64'hB1);
      check_eq("t2_p2_1", qat(p2_q, 1), 64'h0);
      check_eq("t2_p2_2", qat(p2_q, 2), 64'h0);
      check_eq("t2_nrd", 64'(addr_q.size()), 64'd4);
      check_eq("t2_addr1", qat(addr_q, 1), 64'd400);
      check_eq("t2_addr3", qat(addr_q, 3), 64'd302);
      check_eq("t2_cksum", checksum, ck(64'h11));

      // credit stall: no returns, only two pushes fit
      repeat (4) @(posedge clk);
      auto_en = 1'b0;
      job(10'd500, 10'd600, 8'd4, 8'd4, 8'h03);
      repeat (30) @(negedge clk);
      check_eq("t3_stall_nwr", 64'(p1_q.size()), 64'd2);
      check_eq("t3_stall_rd", {63'd0, mem_rd_en}, 64'd0);
      check_eq("t3_stall_nrd", 64'(addr_q.size()), 64'd4);
      check_eq("t3_stall_busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1 genome_id_in = 8'h99; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check_eq("t3_start_ign", {56'd0, genomeID}, 64'h03);
      pulse_credit();
      repeat (10) @(negedge clk);
      check_eq("t3_nwr3", 64'(p1_q.size()), 64'd3);
      check_eq("t3_p1_2", qat(p1_q, 2), 64'd3);
      check_eq("t3_p2_2", qat(p2_q, 2), 64'd7);
      pulse_credit();
      wait_done("t3_done");
      check_eq("t3_nwr4", 64'(p1_q.size()), 64'd4);
      check_eq("t3_p1_3", qat(p1_q, 3), 64'd4);
      check_eq("t3_p2_3", qat(p2_q, 3), 64'd8);
      check_eq("t3_cksum", checksum, ck(64'h08));

      // zero-length job: done only
      job(10'd100, 10'd200, 8'd0, 8'd0, 8'h04);
      wait_done("t4_done");
      check_eq("t4_nwr", 64'(p1_q.size()), 64'd0);
      check_eq("t4_nrd", 64'(addr_q.size()), 64'd0);
      check_eq("t4_cksum", checksum, 64'd0);

      // reset while in RD_B
      pulse_credit();
      pulse_credit();
      job(10'd100, 10'd200, 8'd2, 8'd2, 8'h77);
      begin
         int n = 0;
         while (mem_rd_en !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
         end
         check_eq("t5_rd_seen", {63'd0, mem_rd_en}, 64'd1);
      end
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1;
      check_eq("t5_busy", {63'd0, busy}, 64'd0);
      check_eq("t5_done", {63'd0, done}, 64'd0);
      check_eq("t5_rd_en", {63'd0, mem_rd_en}, 64'd0);
      check_eq("t5_addr", {54'd0, mem_addr}, 64'd0);
      check_eq("t5_wr_en", {63'd0, wr_en}, 64'd0);
      check_eq("t5_p1", parent1, 64'd0);
      check_eq("t5_p2", parent2, 64'd0);
      check_eq("t5_gid", {56'd0, genomeID}, 64'd0);
      check_eq("t5_cksum", checksum, 64'd0);
      reset = 1'b1;
      // credits restored: two pushes complete without any returns
      job(10'd100, 10'd200, 8'd2, 8'd2, 8'h78);
      wait_done("t5_rerun_done");
      check_eq("t5_nwr", 64'(p1_q.size()), 64'd2);
      check_eq("t5_p1_0", qat(p1_q, 0), 64'h11);
      check_eq("t5_p2_1", qat(p2_q, 1), 64'h44);
      check_eq("t5_cksum2", checksum, ck(64'h44));

      // address wrap at top of memory
      pulse_credit();
      pulse_credit();
      auto_en = 1'b1;
      job(10'd1023, 10'd10, 8'd2, 8'd0, 8'h06);
      wait_done("t6_done");
      check_eq("t6_nrd", 64'(addr_q.size()), 64'd2);
      check_eq("t6_addr0", qat(addr_q, 0), 64'd1023);
      check_eq("t6_addr1", qat(addr_q, 1), 64'd0);
      check_eq("t6_p1_0", qat(p1_q, 0), 64'hC1);
      check_eq("t6_p1_1", qat(p1_q, 1), 64'hC2);
      check_eq("t6_p2_1", qat(p2_q, 1), 64'h0);
      check_eq("t6_cksum", checksum, ck(64'h03));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
